asyn_rstb_dff_edge_cell: RTL and testbench

//  Synchronous dual-edge capture and readout-gating cell for one readout slot. A gray-count bit

---
 rtl/asyn_rstb_dff_edge_cell.sv | 82 ++++++++
 tb/tb_asyn_rstb_dff_edge_cell.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/asyn_rstb_dff_edge_cell.sv
// Dual-edge capture and readout-gating cell for one readout slot.
// Gray edges load the pwr level into per-edge registers; the live gray level picks which one enables the bus.
module asyn_rstb_dff_edge_cell #(
  parameter int NCH         = 2,
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pwr,
  input  logic                   gray,
  input  logic                   clr_n,
  input  logic [NCH*WIDTH-1:0]   din,
  output logic [NCH*WIDTH-1:0]   dout,
  output logic                   dout_en,
  output logic                   q_pos,
  output logic                   q_neg
);

  logic [SYNC_STAGES-1:0] syncChain_q;
  logic                   grayDly_q;
  logic                   posCap_q;
  logic                   posCap_d;
  logic                   negCap_q;
  logic                   negCap_d;
  logic                   grayS;
  logic                   riseDet;
  logic                   fallDet;

  assign grayS   = syncChain_q[SYNC_STAGES-1];
  assign riseDet = grayS & ~grayDly_q;
  assign fallDet = ~grayS & grayDly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      syncChain_q <= '0;
      grayDly_q   <= 1'b0;
    end else begin
      syncChain_q[0] <= gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        syncChain_q[i] <= syncChain_q[i-1];
      end
      grayDly_q <= grayS;
    end
  end

  // Clear beats a coincident edge, so an edge seen while clr_n is low is dropped.
  always_comb begin
    posCap_d = posCap_q;
    negCap_d = negCap_q;
    if (!clr_n) begin
      posCap_d = 1'b0;
      negCap_d = 1'b0;
    end else begin
      if (riseDet) posCap_d = pwr;
      if (fallDet) negCap_d = pwr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      posCap_q <= 1'b0;
      negCap_q <= 1'b0;
    end else begin
      posCap_q <= posCap_d;
      negCap_q <= negCap_d;
    end
  end

  // The select moves with grayS a cycle before the new capture lands, giving a one-cycle low gap.
  always_comb begin
    dout_en = grayS ? posCap_q : negCap_q;
    dout    = '0;
    for (int c = 0; c < NCH; c++) begin
      dout[c*WIDTH +: WIDTH] = dout_en ? din[c*WIDTH +: WIDTH] : '0;
    end
  end

  assign q_pos = posCap_q;
  assign q_neg = negCap_q;

endmodule

// File: tb/tb_asyn_rstb_dff_edge_cell.sv
// Directed bench for asyn_rstb_dff_edge_cell: each task drives one scenario and checks
// the packed state {q_pos, q_neg, dout_en, dout} against hand-derived values.
module tb_asyn_rstb_dff_edge_cell;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwr;
  logic       gray;
  logic       clr_n;
  logic [1:0] din;
  logic [1:0] dout;
  logic       dout_en;
  logic       q_pos;
  logic       q_neg;

  int errors = 0;
  int checks = 0;

  asyn_rstb_dff_edge_cell #(.NCH(2), .WIDTH(1), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .pwr     (pwr),
    .gray    (gray),
    .clr_n   (clr_n),
    .din     (din),
    .dout    (dout),
    .dout_en (dout_en),
    .q_pos   (q_pos),
    .q_neg   (q_neg)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 2'b11; pwr = 1'b1; clr_n = 1'b1; gray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      gray = ~gray;
      tick();
      checks++;
      if ({q_pos, q_neg, dout_en, dout} !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc%0d: got %b want 00000", i, {q_pos, q_neg, dout_en, dout});
      end
    end
  endtask

  task automatic test_rise();
    reset = 1'b0; gray = 1'b0; pwr = 1'b1; clr_n = 1'b1; din = 2'b10;
    tick(); tick();
    gray = 1'b1;
    tick();
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL rise_k: got %b want 00000", {q_pos, q_neg, dout_en, dout});
    end
    tick();
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL rise_k1: got %b want 00000", {q_pos, q_neg, dout_en, dout});
    end
    tick();
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b10110) begin
      errors++;
      $display("[TB] FAIL rise_k2: got %b want 10110", {q_pos, q_neg, dout_en, dout});
    end
  endtask

  task automatic test_fall();
    gray = 1'b0;
    tick();
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b10110) begin
      errors++;
      $display("[TB] FAIL fall_k: got %b want 10110", {q_pos, q_neg, dout_en, dout});
    end
    tick();
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL fall_gap: got %b want 10000", {q_pos, q_neg, dout_en, dout});
    end
    din = 2'b01;
    tick();
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b11101) begin
      errors++;
      $display("[TB] FAIL fall_k2: got %b want 11101", {q_pos, q_neg, dout_en, dout});
    end
    din = 2'b11;
    #1;
    checks++;
    if (dout !== 2'b11) begin
      errors++;
      $display("[TB] FAIL fall_din_track: got %b want 11", dout);
    end
  endtask

  task automatic test_clear();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL clear_level: got %b want 00000", {q_pos, q_neg, dout_en, dout});
    end
    gray = 1'b1;
    tick();
    tick();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL clear_on_rise: got %b want 00000", {q_pos, q_neg, dout_en, dout});
    end
    tick();
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL clear_edge_lost: got %b want 00000", {q_pos, q_neg, dout_en, dout});
    end
  endtask

  task automatic test_pwr_low();
    pwr = 1'b0;
    gray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) gray = 1'b1;
      tick();
      checks++;
      if ({q_pos, q_neg, dout_en, dout} !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL pwr_low cyc%0d: got %b want 00000", i, {q_pos, q_neg, dout_en, dout});
      end
    end
  endtask

  task automatic test_back_to_back();
    pwr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) gray = ~gray;
      din = i[0] ? 2'b10 : 2'b01;
      tick();
    end
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b11110) begin
      errors++;
      $display("[TB] FAIL freerun_state: got %b want 11110", {q_pos, q_neg, dout_en, dout});
    end
    din = 2'b01;
    #1;
    checks++;
    if (dout !== 2'b01) begin
      errors++;
      $display("[TB] FAIL freerun_din: got %b want 01", dout);
    end
    reset = 1'b1;
    gray = ~gray;
    tick();
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL midreset: got %b want 00000", {q_pos, q_neg, dout_en, dout});
    end
    gray = ~gray;
    tick();
    reset = 1'b0;
    gray = 1'b0;
    din = 2'b11;
    tick(); tick();
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got %b want 00000", {q_pos, q_neg, dout_en, dout});
    end
    gray = 1'b1;
    tick();
    tick();
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL recover_k1: got %b want 00000", {q_pos, q_neg, dout_en, dout});
    end
    tick();
    checks++;
    if ({q_pos, q_neg, dout_en, dout} !== 5'b10111) begin
      errors++;
      $display("[TB] FAIL recover_k2: got %b want 10111", {q_pos, q_neg, dout_en, dout});
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_clear();
    test_pwr_low();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
